// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: store sizes, FSM states and lane-merge masks.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10,
    SZ_WORD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [31:0] LANE_BYTE = 32'h0000_00FF;
  localparam logic [31:0] LANE_HALF = 32'h0000_FFFF;
  localparam logic [31:0] LANE_WORD = 32'hFFFF_FFFF;

  // Little-endian lane mask: byte offset k occupies bits [8k+7:8k].
  function automatic logic [31:0] lane_mask(input size_e size, input logic [1:0] off);
    logic [31:0] base;
    case (size)
      SZ_BYTE: base = LANE_BYTE;
      SZ_HALF: base = LANE_HALF;
      default: base = LANE_WORD;
    endcase
    return base << {off, 3'b000};
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
    return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_spram_word.sv
// Single-port word-wide synchronous RAM: registered read, one write enable, no reset.
module spram_word #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: 1-cycle right-justified reads, byte/half/word stores (RMW for sub-word).
// Build macro MEM_BOUNDS_CHECK_EN rejects stores and zeroes reads beyond the RAM depth.
//   state | meaning
//   IDLE  | serve reads from address; accept store requests
//   READ  | fetch target word for a sub-word store
//   MERGE | splice latched lanes into the fetched word
//   WRITE | single-cycle RAM write of the assembled word
//   DONE  | done (and error) held until write returns to 00
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int    ADDR_WIDTH = 12,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [1:0]  write,
  input  logic [31:0] d,
  output logic [31:0] q,
  output logic        done,
  output logic        error
);

  localparam bit unused_init_file = (INIT_FILE != "");

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [1:0]            req_off_q, req_off_d;
  size_e                 req_size_q, req_size_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  err_q, err_d;

  logic                  rd_valid_q, rd_valid_d;
  logic [1:0]            rd_off_q, rd_off_d;
  logic                  rd_oob_q, rd_oob_d;
  logic [31:0]           q_hold_q;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [31:0]           ram_rdata;
  logic [31:0]           lane_msk;
  logic [31:0]           merged;
  logic                  addr_oob;
  size_e                 write_sz;

  assign write_sz = size_e'(write);

`ifdef MEM_BOUNDS_CHECK_EN
  assign addr_oob = |address[31:ADDR_WIDTH+2];
`else
  logic unused_upper_bits;
  assign unused_upper_bits = ^address[31:ADDR_WIDTH+2];
  assign addr_oob = 1'b0;
`endif

  spram_word #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      req_addr_q <= '0;
      req_off_q  <= '0;
      req_size_q <= SZ_NONE;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_off_q  <= req_off_d;
      req_size_q <= req_size_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_off_d  = req_off_q;
    req_size_d = req_size_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    ram_addr   = req_addr_q;
    ram_we     = 1'b0;
    lane_msk   = lane_mask(req_size_q, req_off_q);
    merged     = (ram_rdata & ~lane_msk) | ((wdata_q << {req_off_q, 3'b000}) & lane_msk);

    case (state_q)
      ST_IDLE: begin
        ram_addr = address[ADDR_WIDTH+1:2];
        if (write_sz != SZ_NONE) begin
          req_addr_d = address[ADDR_WIDTH+1:2];
          req_off_d  = address[1:0];
          req_size_d = write_sz;
          wdata_d    = d;
          err_d      = 1'b0;
          if (is_misaligned(write_sz, address[1:0]) || addr_oob) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (write_sz == SZ_WORD) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        state_d = ST_MERGE;
      end
      ST_MERGE: begin
        wdata_d = merged;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        ram_we  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (write_sz == SZ_NONE) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A read result is only presented for the cycle after an IDLE lookup; otherwise q holds.
  always_comb begin
    rd_valid_d = (state_q == ST_IDLE);
    rd_off_d   = rd_off_q;
    rd_oob_d   = rd_oob_q;
    if (state_q == ST_IDLE) begin
      rd_off_d = address[1:0];
      rd_oob_d = addr_oob;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_off_q   <= '0;
      rd_oob_q   <= 1'b0;
      q_hold_q   <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_off_q   <= rd_off_d;
      rd_oob_q   <= rd_oob_d;
      q_hold_q   <= q;
    end
  end

  always_comb begin
    q = q_hold_q;
    if (rd_valid_q) begin
      q = rd_oob_q ? '0 : (ram_rdata >> {rd_off_q, 3'b000});
    end
  end

  assign done  = (state_q == ST_DONE);
  assign error = done && err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit against a byte-array reference model.
module tb_mem_access_unit;

  localparam int AW      = 12;
  localparam int DEPTH_B = 4 * (2 ** AW);
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address = '0;
  logic [1:0]  write = 2'b00;
  logic [31:0] d = '0;
  logic [31:0] q;
  logic        done;
  logic        error;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem_b [DEPTH_B];

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_WIDTH(AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .address(address),
    .write  (write),
    .d      (d),
    .q      (q),
    .done   (done),
    .error  (error)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic bit model_oob(input logic [31:0] a);
    return BOUNDS && (a >= 32'(DEPTH_B));
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    int base;
    int off;
    r = '0;
    if (model_oob(a)) return '0;
    base = int'(a % 32'(DEPTH_B)) & ~3;
    off  = int'(a[1:0]);
    for (int k = off; k < 4; k++) r = r | (32'(mem_b[base + k]) << (8 * (k - off)));
    return r;
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [1:0] sz,
                                      input logic [31:0] data, output logic err, output int lat);
    int nb;
    int base;
    nb  = (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : 4;
    err = ((int'(a[1:0]) % nb) != 0) || model_oob(a);
    lat = err ? 1 : ((sz == 2'b11) ? 2 : 4);
    if (!err) begin
      base = int'(a % 32'(DEPTH_B));
      for (int k = 0; k < nb; k++) mem_b[base + k] = data[8*k +: 8];
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] data,
                          input int hold, output int lat, output logic err_seen,
                          output bit held_ok, output bit exit_ok);
    lat      = 0;
    err_seen = 1'b0;
    held_ok  = 1'b1;
    @(negedge clk);
    address = a;
    write   = sz;
    d       = data;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat      = c;
        err_seen = error;
        break;
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      address = $urandom;
      d       = $urandom;
      @(posedge clk); #1;
      if (!done) held_ok = 1'b0;
    end
    @(negedge clk);
    write = 2'b00;
    @(posedge clk); #1;
    exit_ok = !done && !error;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] qv);
    @(negedge clk);
    address = a;
    write   = 2'b00;
    @(posedge clk); #1;
    qv = q;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (q !== 32'h0) begin n_err++; $display("FAIL reset_q: got %h expected %h", q, 32'h0); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_vec++; if (error !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b expected 0", error); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_word_store();
    int lat, elat; logic err, eerr; bit hok, xok; logic [31:0] qv;
    do_store(32'h100, 2'b11, 32'hDEAD_BEEF, 0, lat, err, hok, xok);
    model_store(32'h100, 2'b11, 32'hDEAD_BEEF, eerr, elat);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL word_latency: got %0d expected 2", lat); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL word_error: got %b expected 0", err); end
    n_vec++; if (xok !== 1'b1) begin n_err++; $display("FAIL word_exit: done/error still high after write=00"); end
    do_read(32'h100, qv);
    n_vec++; if (qv !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL word_read: got %h expected %h", qv, 32'hDEAD_BEEF); end
    do_read(32'h102, qv);
    n_vec++; if (qv !== 32'h0000_DEAD) begin n_err++; $display("FAIL word_read_off2: got %h expected %h", qv, 32'h0000_DEAD); end
  endtask

  task automatic test_byte_merge();
    int lat, elat; logic err, eerr; bit hok, xok; logic [31:0] qv;
    do_store(32'h101, 2'b01, 32'h0000_0055, 0, lat, err, hok, xok);
    model_store(32'h101, 2'b01, 32'h0000_0055, eerr, elat);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL byte_latency: got %0d expected 4", lat); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL byte_error: got %b expected 0", err); end
    do_read(32'h100, qv);
    n_vec++; if (qv !== 32'hDEAD_55EF) begin n_err++; $display("FAIL byte_read_100: got %h expected %h", qv, 32'hDEAD_55EF); end
    do_read(32'h101, qv);
    n_vec++; if (qv !== 32'h00DE_AD55) begin n_err++; $display("FAIL byte_read_101: got %h expected %h", qv, 32'h00DE_AD55); end
  endtask

  task automatic test_misaligned();
    int lat, elat; logic err, eerr; bit hok, xok; logic [31:0] qv;
    do_store(32'h103, 2'b10, 32'h0000_1234, 0, lat, err, hok, xok);
    model_store(32'h103, 2'b10, 32'h0000_1234, eerr, elat);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL misaligned_half_latency: got %0d expected 1", lat); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL misaligned_half_error: got %b expected 1", err); end
    n_vec++; if (xok !== 1'b1) begin n_err++; $display("FAIL misaligned_exit: done/error still high after write=00"); end
    do_store(32'h102, 2'b11, 32'hFFFF_FFFF, 0, lat, err, hok, xok);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL misaligned_word_error: got %b expected 1", err); end
    do_read(32'h100, qv);
    n_vec++; if (qv !== 32'hDEAD_55EF) begin n_err++; $display("FAIL misaligned_untouched: got %h expected %h", qv, 32'hDEAD_55EF); end
  endtask

  task automatic test_back_to_back();
    int lat, elat; logic err, eerr; bit hok, xok; logic [31:0] qv;
    do_store(32'h104, 2'b11, 32'h1111_2222, 5, lat, err, hok, xok);
    model_store(32'h104, 2'b11, 32'h1111_2222, eerr, elat);
    n_vec++; if (hok !== 1'b1) begin n_err++; $display("FAIL hold_done: done dropped while write held, expected held high"); end
    n_vec++; if (xok !== 1'b1) begin n_err++; $display("FAIL hold_exit: done still high one cycle after write=00"); end
    do_read(32'h104, qv);
    n_vec++; if (qv !== 32'h1111_2222) begin n_err++; $display("FAIL hold_no_reaccept: got %h expected %h", qv, 32'h1111_2222); end
    do_store(32'h104, 2'b01, 32'h0000_0099, 0, lat, err, hok, xok);
    model_store(32'h104, 2'b01, 32'h0000_0099, eerr, elat);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL second_store_latency: got %0d expected 4", lat); end
    do_read(32'h104, qv);
    n_vec++; if (qv !== 32'h1111_2299) begin n_err++; $display("FAIL second_store_read: got %h expected %h", qv, 32'h1111_2299); end
  endtask

  task automatic test_drop_mid_sequence();
    int lat, elat; logic err, eerr; bit hok, xok; logic [31:0] qv;
    do_store(32'h108, 2'b11, 32'h0, 0, lat, err, hok, xok);
    model_store(32'h108, 2'b11, 32'h0, eerr, elat);
    @(negedge clk);
    address = 32'h10B; write = 2'b01; d = 32'h77;
    @(posedge clk); #1;
    @(negedge clk);
    write = 2'b00;
    lat = 0;
    for (int c = 2; c <= 8; c++) begin
      @(posedge clk); #1;
      if (done) begin lat = c; break; end
    end
    model_store(32'h10B, 2'b01, 32'h77, eerr, elat);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL drop_latency: got %0d expected 4", lat); end
    @(posedge clk); #1;
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL drop_exit: done got %b expected 0", done); end
    do_read(32'h108, qv);
    n_vec++; if (qv !== 32'h7700_0000) begin n_err++; $display("FAIL drop_read: got %h expected %h", qv, 32'h7700_0000); end
  endtask

  task automatic test_reset_mid_merge();
    int lat, elat; logic err, eerr; bit hok, xok; logic [31:0] qv;
    do_store(32'h200, 2'b11, 32'hCAFE_F00D, 0, lat, err, hok, xok);
    model_store(32'h200, 2'b11, 32'hCAFE_F00D, eerr, elat);
    @(negedge clk);
    address = 32'h200; write = 2'b01; d = 32'hAA;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_merge_done: got %b expected 0", done); end
    n_vec++; if (error !== 1'b0) begin n_err++; $display("FAIL rst_merge_error: got %b expected 0", error); end
    n_vec++; if (q !== 32'h0) begin n_err++; $display("FAIL rst_merge_q: got %h expected 0", q); end
    write = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    do_read(32'h200, qv);
    n_vec++; if (qv !== model_read(32'h200)) begin n_err++; $display("FAIL rst_merge_unchanged: got %h expected %h", qv, model_read(32'h200)); end
  endtask

  task automatic test_wrap();
    int lat, elat; logic err, eerr; bit hok, xok; logic [31:0] qv;
    do_store(32'h0, 2'b11, 32'h0102_0304, 0, lat, err, hok, xok);
    model_store(32'h0, 2'b11, 32'h0102_0304, eerr, elat);
    do_store(32'h0001_0000, 2'b11, 32'hA5A5_5A5A, 0, lat, err, hok, xok);
    model_store(32'h0001_0000, 2'b11, 32'hA5A5_5A5A, eerr, elat);
    n_vec++; if (lat !== elat) begin n_err++; $display("FAIL wrap_latency: got %0d expected %0d", lat, elat); end
    n_vec++; if (err !== eerr) begin n_err++; $display("FAIL wrap_error: got %b expected %b", err, eerr); end
    do_read(32'h0, qv);
    n_vec++; if (qv !== model_read(32'h0)) begin n_err++; $display("FAIL wrap_read0: got %h expected %h", qv, model_read(32'h0)); end
    do_read(32'h0001_0001, qv);
    n_vec++; if (qv !== model_read(32'h0001_0001)) begin n_err++; $display("FAIL wrap_read_high: got %h expected %h", qv, model_read(32'h0001_0001)); end
  endtask

  task automatic test_random();
    int lat, elat; logic err, eerr; bit hok, xok; logic [31:0] qv, a, data;
    int op, hold;
    for (int w = 0; w < 32; w++) begin
      data = $urandom;
      do_store(32'(4 * w), 2'b11, data, 0, lat, err, hok, xok);
      model_store(32'(4 * w), 2'b11, data, eerr, elat);
      n_vec++; if (lat !== elat) begin n_err++; $display("FAIL rand_init_latency: addr %h got %0d expected %0d", 4 * w, lat, elat); end
    end
    for (int i = 0; i < 100; i++) begin
      op = int'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << 14);
      if (op == 0) begin
        do_read(a, qv);
        n_vec++; if (qv !== model_read(a)) begin n_err++; $display("FAIL rand_read: addr %h got %h expected %h", a, qv, model_read(a)); end
      end else begin
        data = $urandom;
        hold = int'($urandom_range(0, 2));
        do_store(a, 2'(op), data, hold, lat, err, hok, xok);
        model_store(a, 2'(op), data, eerr, elat);
        n_vec++; if (lat !== elat) begin n_err++; $display("FAIL rand_latency: addr %h size %0d got %0d expected %0d", a, op, lat, elat); end
        n_vec++; if (err !== eerr) begin n_err++; $display("FAIL rand_error: addr %h size %0d got %b expected %b", a, op, err, eerr); end
        n_vec++; if (hok !== 1'b1) begin n_err++; $display("FAIL rand_hold: addr %h done dropped during hold, expected high", a); end
        n_vec++; if (xok !== 1'b1) begin n_err++; $display("FAIL rand_exit: addr %h done/error high after write=00, expected low", a); end
      end
    end
    for (int w = 0; w < 32; w++) begin
      do_read(32'(4 * w), qv);
      n_vec++; if (qv !== model_read(32'(4 * w))) begin n_err++; $display("FAIL rand_final: addr %h got %h expected %h", 4 * w, qv, model_read(32'(4 * w))); end
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_merge();
    test_misaligned();
    test_back_to_back();
    test_drop_mid_sequence();
    test_reset_mid_merge();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
